// File: rtl/dst_channel_fifo_if.sv
// Valid/ready stream carrying one DATA_W beat per handshake.
// No storage; purely the wires between a producer and a consumer.
// Producer holds valid/data until ready is seen; consumer drives ready.
interface dst_channel_fifo_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  // Producer side: drives valid/data, observes ready.
  modport master (output valid, output data, input ready);
  // Consumer side: observes valid/data, drives ready.
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dst_channel_fifo.sv
// First-word-fall-through output buffer between the arbiter and a stalling sink.
// Latency: a beat pushed on an edge is on out_data after that edge (1 cycle, no bypass).
// Backpressure: in_ready = not full, from registered level only; a full FIFO refuses a push even while popping.
module dst_channel_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dst_channel_fifo_if.slave      in_s,
  dst_channel_fifo_if.master     out_s,
  output logic [$clog2(DEPTH):0] level,
  output logic [STALL_W-1:0]     stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Ready/valid are pure functions of the level register, so the sink's ready
  // never reaches the arbiter combinationally.
  assign in_s.ready  = (level != LVL_FULL);
  assign out_s.valid = (level != '0);
  // Storage is not reset; mask the head so an empty FIFO presents zero.
  assign out_s.data  = out_s.valid ? mem[rd_ptr] : '0;

  assign push = in_s.valid & in_s.ready;
  assign pop  = out_s.valid & out_s.ready;

  // Write the incoming beat into the tail slot; storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_s.data;
    end
  end

  // Pointers wrap naturally; level is tracked explicitly rather than derived from them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Count cycles where the head is offered but the sink stalls; stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (out_s.valid && !out_s.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
